// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage; holds the pipeline with stall while running.
// Latency: MUL_CYCLES+1 (multiply) or WIDTH+1 (divide) cycles from start to result_valid; annul aborts at once.
module muldiv_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 16);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             sgn_q;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;

    logic             idle_like;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign stall = resetn & ~annul & ((start & idle_like) | (state == MUL) | (state == DIV));

    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // One restoring step: the dividend register doubles as the quotient shift register.
    assign trial   = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    assign rem_nx  = trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_nx  = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    assign quo_fix = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
    assign rem_fix = a_neg ? -rem_nx : rem_nx;

    // Low 2W bits of the extended product are correct for both signednesses.
    assign a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            hi           <= '0;
            lo           <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            sgn_q        <= 1'b0;
            a_neg        <= 1'b0;
            b_neg        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rem          <= '0;
            dvd          <= '0;
            dvs          <= '0;
        end else if (annul) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    result_valid <= 1'b0;
                    cnt          <= '0;
                    if (start) begin
                        state <= is_div ? DIV : MUL;
                        busy  <= 1'b1;
                        sgn_q <= is_signed;
                        a_neg <= is_signed & a[WIDTH-1];
                        b_neg <= is_signed & b[WIDTH-1];
                        a_q   <= a;
                        b_q   <= b;
                        rem   <= '0;
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == MUL_LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        hi           <= prod[2*WIDTH-1:WIDTH];
                        lo           <= prod[WIDTH-1:0];
                    end
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    rem <= rem_nx;
                    dvd <= quo_nx;
                    if (cnt == DIV_LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        if (b_q == '0) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, stall, fix-ups, divide-by-zero, back-to-back, annul and reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        is_div;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int seen;

    muldiv_seq #(.WIDTH(32), .MUL_CYCLES(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .is_div       (is_div),
        .is_signed    (is_signed),
        .a            (a),
        .b            (b),
        .annul        (annul),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issues an op now and returns (at negedge+1) inside its DONE cycle.
    task automatic run_op(input string tag, input logic d, input logic s,
                          input logic [31:0] av, input logic [31:0] bv, input int lat,
                          input logic [31:0] eh, input logic [31:0] el, input logic noisy);
        start = 1'b1; is_div = d; is_signed = s; a = av; b = bv;
        #1;
        chk({tag, ".stall_c0"}, {31'b0, stall}, 32'd1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (noisy) begin
                a = $urandom; b = $urandom;
                is_div = 1'($urandom); is_signed = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            #1;
            if (c < lat) begin
                chk({tag, ".run"}, {30'b0, stall, result_valid}, 32'b10);
            end else begin
                chk({tag, ".valid"}, {31'b0, result_valid}, 32'd1);
                chk({tag, ".hi"}, hi, eh);
                chk({tag, ".lo"}, lo, el);
                chk({tag, ".stall_done"}, {31'b0, stall}, {31'b0, noisy});
            end
        end
    endtask

    task automatic idle_chk(input string tag);
        start = 1'b0;
        @(negedge clk); #1;
        chk({tag, ".pulse_end"}, {30'b0, result_valid, busy}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b1; is_div = 1'b1; is_signed = 1'b0;
        a = 32'd9; b = 32'd3; annul = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.flags", {29'b0, stall, busy, result_valid}, 32'd0);
        resetn = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        chk("rst.idle", {30'b0, busy, stall}, 32'd0);

        run_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
        idle_chk("divu_100_7");
        run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        idle_chk("div_m7_2");
        run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0);
        idle_chk("div_ovf");
        run_op("div_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        idle_chk("div_m5_0");
        run_op("mult", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        idle_chk("mult");
        run_op("multu", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 2, 32'd1, 32'hFFFF_FFFE, 1'b0);
        idle_chk("multu");

        // Divide by zero followed by a start issued in its DONE cycle.
        run_op("divu_by0", 1'b1, 1'b0, 32'h1234, 32'd0, 33, 32'h1234, 32'hFFFF_FFFF, 1'b0);
        run_op("b2b_multu", 1'b0, 1'b0, 32'd3, 32'd5, 2, 32'd0, 32'd15, 1'b0);
        idle_chk("b2b_multu");

        // Start held and operands scrambled while the divide runs.
        run_op("div_noisy", 1'b1, 1'b1, 32'd1000, 32'hFFFF_FFFD, 33, 32'd1, 32'hFFFF_FEB3, 1'b1);
        idle_chk("div_noisy");

        // Annul in divide cycle 10.
        start = 1'b1; is_div = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        annul = 1'b1;
        #1;
        chk("annul.stall", {31'b0, stall}, 32'd0);
        chk("annul.busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul.after", {29'b0, busy, stall, result_valid}, 32'd0);
        chk("annul.hi", hi, 32'd1);
        chk("annul.lo", lo, 32'hFFFF_FEB3);
        seen = 0;
        repeat (35) begin
            @(negedge clk); #1;
            if (result_valid) seen++;
        end
        chk("annul.no_valid", seen, 32'd0);

        // Reset in divide cycle 5.
        start = 1'b1; is_div = 1'b1; is_signed = 1'b1; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("rst_mid.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_mid.hi", hi, 32'd0);
        chk("rst_mid.lo", lo, 32'd0);
        chk("rst_mid.busy", {31'b0, busy}, 32'd0);
        seen = 0;
        repeat (35) begin
            @(negedge clk); #1;
            if (result_valid) seen++;
        end
        chk("rst_mid.no_valid", seen, 32'd0);

        @(negedge clk);
        run_op("recover_multu", 1'b0, 1'b0, 32'd6, 32'd7, 2, 32'd0, 32'd42, 1'b0);
        idle_chk("recover_multu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
